// File: rtl/nexusv_mem_arbiter.sv
// Shares the core's single memory port between instruction fetch and load/store.
// Data wins ties unless fetch has lost STARVE_MAX ties in a row; one access in flight.
module nexusv_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             if_req,
  input  logic [ADDR_W-1:0]                if_addr,
  output logic                             if_ack,
  output logic [DATA_W-1:0]                if_rdata,
  input  logic                             d_req,
  input  logic                             d_we,
  input  logic [DATA_W/8-1:0]              d_be,
  input  logic [ADDR_W-1:0]                d_addr,
  input  logic [DATA_W-1:0]                d_wdata,
  output logic                             d_ack,
  output logic [DATA_W-1:0]                d_rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [DATA_W/8-1:0]              mem_be,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic                             mem_ready,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic                             owner,
  output logic                             busy,
  output logic [1:0]                       dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]  dbg_starve_cnt
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_MAX);

  // Handshakes: a requester holds req and a stable payload until its one-cycle
  // ack; the payload is registered at grant, so later changes are ignored. On the
  // memory side mem_req and mem_* stay constant until mem_ready is sampled high,
  // and mem_rdata is taken in that same cycle.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_fetch;
  logic             grant_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration only happens in IDLE; RESP deliberately skips it so a request
  // still high during its own ack cycle is not granted twice.
  always_comb begin
    state_nxt   = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (if_req && d_req) begin
          if (starve_cnt == CNT_LIM) begin
            grant_fetch = 1'b1;
          end else begin
            grant_data = 1'b1;
          end
        end else begin
          grant_fetch = if_req;
          grant_data  = d_req;
        end
        if (grant_fetch || grant_data) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Decoded straight from the state register, so reset drops them at once.
  always_comb begin
    mem_req        = (state == S_BUSY);
    if_ack         = (state == S_RESP) && !owner;
    d_ack          = (state == S_RESP) && owner;
    busy           = (state != S_IDLE);
    dbg_state      = state;
    dbg_starve_cnt = starve_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= 1'b0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if (grant_fetch) begin
        mem_we     <= 1'b0;
        mem_be     <= '1;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        owner      <= 1'b0;
        starve_cnt <= '0;
      end else if (grant_data) begin
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        owner     <= 1'b1;
        // A data grant only costs fetch a loss when fetch was also asking.
        if (if_req && (starve_cnt != CNT_LIM)) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end
      if ((state == S_BUSY) && mem_ready) begin
        if (!owner) begin
          if_rdata <= mem_rdata;
        end else if (!mem_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_nexusv_mem_arbiter.sv
// Bench for nexusv_mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level timing/arbitration model.
module tb_nexusv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          owner;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_starve_cnt;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_d_rdata  = '0;

  nexusv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
    checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL rst_mem_be got=%h exp=0", mem_be); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if ({if_ack, d_ack} !== 2'b00) begin failures++; $display("FAIL rst_acks got=%b exp=00", {if_ack, d_ack}); end
    checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
    checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
    checks++; if ({owner, busy} !== 2'b00) begin failures++; $display("FAIL rst_owner_busy got=%b exp=00", {owner, busy}); end
    checks++; if (dbg_starve_cnt !== 3'd0) begin failures++; $display("FAIL rst_starve got=%0d exp=0", dbg_starve_cnt); end
    rst_n = 1'b1;
    tick();
    checks++; if ({mem_req, busy} !== 2'b00) begin failures++; $display("FAIL rst_release got=%b exp=00", {mem_req, busy}); end
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_mem_req got=%0b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_mem_addr got=%h exp=100", mem_addr); end
    checks++; if ({mem_we, mem_be} !== 5'b0_1111) begin failures++; $display("FAIL fetch_we_be got=%b exp=01111", {mem_we, mem_be}); end
    checks++; if ({owner, busy} !== 2'b01) begin failures++; $display("FAIL fetch_owner_busy got=%b exp=01", {owner, busy}); end
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    tick();
    mem_ready = 1'b0; if_req = 1'b0;
    exp_if_rdata = 32'h00500093;
    checks++; if ({if_ack, d_ack} !== 2'b10) begin failures++; $display("FAIL fetch_ack got=%b exp=10", {if_ack, d_ack}); end
    checks++; if (if_rdata !== exp_if_rdata) begin failures++; $display("FAIL fetch_rdata got=%h exp=%h", if_rdata, exp_if_rdata); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_mem_drop got=%0b exp=0", mem_req); end
    tick();
    checks++; if ({if_ack, d_ack, busy} !== 3'b000) begin failures++; $display("FAIL fetch_done got=%b exp=000", {if_ack, d_ack, busy}); end
  endtask

  task automatic test_store_waits();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_req, d_ack} !== 2'b10) begin failures++; $display("FAIL store_wait%0d req_ack got=%b exp=10", i, {mem_req, d_ack}); end
      checks++;
      if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'h3, 32'h2000, 32'hDEADBEEF}) begin
        failures++; $display("FAIL store_wait%0d payload got=%b/%h/%h/%h exp=1/3/2000/deadbeef", i, mem_we, mem_be, mem_addr, mem_wdata);
      end
      if (i == 1) d_addr = 32'h3000;
      mem_ready = (i == 3); mem_rdata = 32'h12345678;
      tick();
    end
    mem_ready = 1'b0; d_req = 1'b0;
    checks++; if ({d_ack, if_ack, mem_req} !== 3'b100) begin failures++; $display("FAIL store_ack got=%b exp=100", {d_ack, if_ack, mem_req}); end
    checks++; if (d_rdata !== exp_d_rdata) begin failures++; $display("FAIL store_d_rdata got=%h exp=%h", d_rdata, exp_d_rdata); end
    tick();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
    tick();
    checks++; if ({owner, mem_addr} !== {1'b1, 32'h80}) begin failures++; $display("FAIL simul_first got=%0b/%h exp=1/80", owner, mem_addr); end
    checks++; if (dbg_starve_cnt !== 3'd1) begin failures++; $display("FAIL simul_starve1 got=%0d exp=1", dbg_starve_cnt); end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_ready = 1'b0; d_req = 1'b0;
    exp_d_rdata = 32'hCAFE0001;
    checks++; if ({d_ack, d_rdata} !== {1'b1, exp_d_rdata}) begin failures++; $display("FAIL simul_d_ack got=%0b/%h exp=1/%h", d_ack, d_rdata, exp_d_rdata); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL simul_idle got=%0b exp=0", busy); end
    tick();
    checks++; if ({owner, mem_req, mem_addr} !== {2'b01, 32'h40}) begin failures++; $display("FAIL simul_second got=%0b/%0b/%h exp=0/1/40", owner, mem_req, mem_addr); end
    checks++; if (dbg_starve_cnt !== 3'd0) begin failures++; $display("FAIL simul_starve0 got=%0d exp=0", dbg_starve_cnt); end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0002;
    tick();
    mem_ready = 1'b0; if_req = 1'b0;
    exp_if_rdata = 32'hCAFE0002;
    checks++; if ({if_ack, if_rdata} !== {1'b1, exp_if_rdata}) begin failures++; $display("FAIL simul_if_ack got=%0b/%h exp=1/%h", if_ack, if_rdata, exp_if_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    logic [DW-1:0] rd;
    logic exp_own;
    if_req = 1'b1; if_addr = 32'h700;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h900;
    for (int g = 0; g < 2 * (SM + 1); g++) begin
      int n = 0;
      while (!mem_req && n < 8) begin tick(); n++; end
      exp_own = ((g % (SM + 1)) == SM) ? 1'b0 : 1'b1;
      checks++; if ({mem_req, owner} !== {1'b1, exp_own}) begin failures++; $display("FAIL starve_grant%0d got=%0b/%0b exp=1/%0b", g, mem_req, owner, exp_own); end
      rd = $urandom;
      mem_ready = 1'b1; mem_rdata = rd;
      tick();
      mem_ready = 1'b0;
      if (exp_own) exp_d_rdata = rd; else exp_if_rdata = rd;
      checks++; if ({if_ack, d_ack} !== {~exp_own, exp_own}) begin failures++; $display("FAIL starve_ack%0d got=%b exp=%b", g, {if_ack, d_ack}, {~exp_own, exp_own}); end
      if (g == 2 * (SM + 1) - 1) begin if_req = 1'b0; d_req = 1'b0; end
      tick();
    end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL starve_end_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500;
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin failures++; $display("FAIL b2b_first got=%0b/%h exp=1/500", mem_req, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'hA1A1A1A1;
    tick();
    mem_ready = 1'b0; d_addr = 32'h504;
    exp_d_rdata = 32'hA1A1A1A1;
    checks++; if ({d_ack, d_rdata} !== {1'b1, exp_d_rdata}) begin failures++; $display("FAIL b2b_ack1 got=%0b/%h exp=1/%h", d_ack, d_rdata, exp_d_rdata); end
    tick();
    checks++; if ({mem_req, busy} !== 2'b00) begin failures++; $display("FAIL b2b_no_resp_grant got=%b exp=00", {mem_req, busy}); end
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h504}) begin failures++; $display("FAIL b2b_second got=%0b/%h exp=1/504", mem_req, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'hB2B2B2B2;
    tick();
    mem_ready = 1'b0; d_req = 1'b0;
    exp_d_rdata = 32'hB2B2B2B2;
    checks++; if ({d_ack, d_rdata} !== {1'b1, exp_d_rdata}) begin failures++; $display("FAIL b2b_ack2 got=%0b/%h exp=1/%h", d_ack, d_rdata, exp_d_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h640;
    tick();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0b exp=1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, busy, if_ack, d_ack} !== 4'b0000) begin failures++; $display("FAIL rmid_async got=%b exp=0000", {mem_req, busy, if_ack, d_ack}); end
    idle_inputs();
    exp_if_rdata = '0; exp_d_rdata = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({mem_req, busy, if_ack, d_ack} !== 4'b0000) begin failures++; $display("FAIL rmid_after%0d got=%b exp=0000", i, {mem_req, busy, if_ack, d_ack}); end
    end
  endtask

  task automatic test_random();
    int cyc = 0, grant_cyc = 0, ready_cyc = -1, losses = 0, wait_left = 0;
    int f_gap, d_gap;
    bit m_busy = 1'b0, m_owner = 1'b0, mem_done = 1'b0;
    bit exp_mreq, exp_ia, exp_da, exp_busy;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic m_we = 1'b0;
    logic [3:0] m_be = '0;
    f_gap = $urandom_range(0, 3);
    d_gap = $urandom_range(0, 3);
    for (int it = 0; it < 3000; it++) begin
      if (m_busy && ready_cyc >= 0 && cyc >= ready_cyc + 2) m_busy = 1'b0;
      if (m_busy && cyc - grant_cyc > 40) begin
        checks++; failures++; $display("FAIL rand_timeout cyc=%0d grant=%0d no completion", cyc, grant_cyc);
        m_busy = 1'b0;
      end
      if (!m_busy && (if_req || d_req)) begin
        if (if_req && d_req) begin
          if (losses >= SM) begin m_owner = 1'b0; losses = 0; end
          else begin m_owner = 1'b1; losses = (losses + 1 > SM) ? SM : losses + 1; end
        end else if (if_req) begin
          m_owner = 1'b0; losses = 0;
        end else begin
          m_owner = 1'b1;
        end
        if (!m_owner) begin m_addr = if_addr; m_we = 1'b0; m_be = 4'hF; m_wdata = '0; end
        else begin m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata; end
        m_busy = 1'b1; grant_cyc = cyc; ready_cyc = -1; mem_done = 1'b0;
        wait_left = $urandom_range(0, 3);
      end
      tick();
      exp_mreq = m_busy && (ready_cyc < 0 || cyc < ready_cyc);
      exp_busy = m_busy && (ready_cyc < 0 || cyc <= ready_cyc);
      exp_ia   = m_busy && (ready_cyc == cyc) && !m_owner;
      exp_da   = m_busy && (ready_cyc == cyc) && m_owner;
      if (exp_ia) exp_if_rdata = mem_word(m_addr);
      if (exp_da && !m_we) exp_d_rdata = mem_word(m_addr);
      checks++; if (mem_req !== exp_mreq) begin failures++; $display("FAIL rand_mem_req cyc=%0d got=%0b exp=%0b", cyc, mem_req, exp_mreq); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", cyc, busy, exp_busy); end
      checks++; if ({if_ack, d_ack} !== {exp_ia, exp_da}) begin failures++; $display("FAIL rand_acks cyc=%0d got=%b exp=%b", cyc, {if_ack, d_ack}, {exp_ia, exp_da}); end
      checks++; if (if_rdata !== exp_if_rdata) begin failures++; $display("FAIL rand_if_rdata cyc=%0d got=%h exp=%h", cyc, if_rdata, exp_if_rdata); end
      checks++; if (d_rdata !== exp_d_rdata) begin failures++; $display("FAIL rand_d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata, exp_d_rdata); end
      if (exp_mreq) begin
        checks++;
        if ({owner, mem_we, mem_be, mem_addr} !== {m_owner, m_we, m_be, m_addr}) begin
          failures++; $display("FAIL rand_payload cyc=%0d got=%0b/%0b/%h/%h exp=%0b/%0b/%h/%h", cyc, owner, mem_we, mem_be, mem_addr, m_owner, m_we, m_be, m_addr);
        end
        if (m_owner) begin
          checks++; if (mem_wdata !== m_wdata) begin failures++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, m_wdata); end
        end
        checks++; if (dbg_starve_cnt !== 3'(losses)) begin failures++; $display("FAIL rand_starve cyc=%0d got=%0d exp=%0d", cyc, dbg_starve_cnt, losses); end
      end
      // Memory responder
      mem_ready = 1'b0; mem_rdata = $urandom;
      if (m_busy && !mem_done && mem_req) begin
        if (wait_left == 0) begin
          mem_ready = 1'b1; mem_rdata = mem_word(m_addr); ready_cyc = cyc + 1; mem_done = 1'b1;
        end else begin
          wait_left--;
        end
      end
      // Fetch requester
      if (exp_ia) begin
        if ($urandom_range(0, 1) == 1) if_addr = $urandom;
        else begin if_req = 1'b0; f_gap = $urandom_range(0, 4); end
      end else if (!if_req) begin
        if (f_gap == 0) begin if_req = 1'b1; if_addr = $urandom; end else f_gap--;
      end else if (exp_mreq && !m_owner && $urandom_range(0, 3) == 0) begin
        if_addr = $urandom;
      end
      // Data requester
      if (exp_da) begin
        if ($urandom_range(0, 1) == 1) begin
          d_we = $urandom_range(0, 1); d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
        end else begin d_req = 1'b0; d_gap = $urandom_range(0, 4); end
      end else if (!d_req) begin
        if (d_gap == 0) begin
          d_req = 1'b1; d_we = $urandom_range(0, 1); d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
        end else d_gap--;
      end else if (exp_mreq && m_owner && $urandom_range(0, 3) == 0) begin
        d_addr = $urandom; d_wdata = $urandom;
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_waits();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
